// File: rtl/fxp_divider.sv
// rtl/fxp_divider.sv - sequential sign-magnitude fixed-point restoring divider
//
// Purpose: quot = num / den for sign-magnitude words whose N-1 magnitude bits
//          are all fractional (value = mag / 2^(N-1)). One quotient bit per clock.
// Optional feature: define FXDIV_ROUND_EN for round-half-up (one extra CALC step);
//          undefined gives truncation toward zero.
// Ports:
//   clk, rst               clock (rising edge), synchronous active-high reset
//   in_valid/in_ready      operand handshake; in_ready is high only in IDLE
//   num, den [N-1:0]       dividend, divisor (sign-magnitude)
//   out_valid/out_ready    result handshake; result held until out_ready
//   quot [N-1:0]           quotient (sign-magnitude)
//   ovf                    saturated result (|num| >= |den|, or rounding carry)
//   dbz                    divisor magnitude was zero
module fxp_divider #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] num,
    input  logic [N-1:0] den,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] quot,
    output logic         ovf,
    output logic         dbz
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 2);
`ifdef FXDIV_ROUND_EN
    localparam logic [CW-1:0] RND_CNT = CW'(N - 1);
`endif

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t        state_q, state_d;
    logic          sign_q, sign_d;
    logic [N-2:0]  dm_q, dm_d;
    logic [N-1:0]  rem_q, rem_d;
    logic [N-2:0]  q_q, q_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  quot_q, quot_d;
    logic          ovf_q, ovf_d;
    logic          dbz_q, dbz_d;

    logic          sign_in;
    logic [N-1:0]  r2;
    logic          qbit;
    logic [N-1:0]  r2_sub;
    logic [N-2:0]  q_shift;
`ifdef FXDIV_ROUND_EN
    logic [N-1:0]  q_rnd;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sign_q  <= 1'b0;
            dm_q    <= '0;
            rem_q   <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            ovf_q   <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            dm_q    <= dm_d;
            rem_q   <= rem_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            ovf_q   <= ovf_d;
            dbz_q   <= dbz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        dm_d    = dm_q;
        rem_d   = rem_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        ovf_d   = ovf_q;
        dbz_d   = dbz_q;

        sign_in = num[N-1] ^ den[N-1];

        // Restoring step. rem < dm < 2^(N-1) always holds, so the doubled
        // remainder fits in N bits. During the rounding step qbit doubles as
        // the "2*rem >= dm" round-up decision.
        r2      = {rem_q[N-2:0], 1'b0};
        qbit    = (r2 >= {1'b0, dm_q});
        r2_sub  = qbit ? (r2 - {1'b0, dm_q}) : r2;
        q_shift = {q_q[N-3:0], qbit};
`ifdef FXDIV_ROUND_EN
        q_rnd   = {1'b0, q_q} + {{(N-1){1'b0}}, qbit};
`endif

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d = sign_in;
                    dm_d   = den[N-2:0];
                    rem_d  = {1'b0, num[N-2:0]};
                    q_d    = '0;
                    cnt_d  = '0;
                    if (den[N-2:0] == '0) begin
                        dbz_d   = 1'b1;
                        ovf_d   = 1'b0;
                        quot_d  = {sign_in, {(N-1){1'b1}}};
                        state_d = DONE;
                    end else if (num[N-2:0] >= den[N-2:0]) begin
                        dbz_d   = 1'b0;
                        ovf_d   = 1'b1;
                        quot_d  = {sign_in, {(N-1){1'b1}}};
                        state_d = DONE;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
`ifdef FXDIV_ROUND_EN
                if (cnt_q == RND_CNT) begin
                    ovf_d   = q_rnd[N-1];
                    dbz_d   = 1'b0;
                    quot_d  = q_rnd[N-1] ? {sign_q, {(N-1){1'b1}}}
                                         : {sign_q, q_rnd[N-2:0]};
                    state_d = DONE;
                end else begin
                    rem_d = r2_sub;
                    q_d   = q_shift;
                    cnt_d = cnt_q + CW'(1);
                end
`else
                rem_d = r2_sub;
                q_d   = q_shift;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_CNT) begin
                    ovf_d   = 1'b0;
                    dbz_d   = 1'b0;
                    quot_d  = {sign_q, q_shift};
                    state_d = DONE;
                end
`endif
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign quot      = quot_q;
    assign ovf       = ovf_q;
    assign dbz       = dbz_q;

endmodule

// File: tb/tb_fxp_divider.sv
// tb/tb_fxp_divider.sv - self-checking bench for fxp_divider at N=8
module tb_fxp_divider;

    localparam int N = 8;
`ifdef FXDIV_ROUND_EN
    localparam int LAT = 8;
`else
    localparam int LAT = 7;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] num;
    logic [N-1:0] den;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] quot;
    logic         ovf;
    logic         dbz;

    int errors = 0;
    int checks = 0;

    fxp_divider #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .num       (num),
        .den       (den),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quot      (quot),
        .ovf       (ovf),
        .dbz       (dbz)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] n;
        logic [7:0] d;
        logic [7:0] q_trunc;
        logic [7:0] q_round;
        logic       o;
        logic       z;
        logic       early;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Latency is counted in clock edges after the acceptance edge; the early
    // exit is already visible right after the acceptance edge (0 extra edges).
    task automatic do_op(input logic [7:0] n, input logic [7:0] d, input int hold,
                         output logic [7:0] q, output logic o, output logic z,
                         output int lat);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) check("in_ready_timeout", 0, 1);
        in_valid = 1'b1;
        num      = n;
        den      = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        num      = 8'($urandom);
        den      = 8'($urandom);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (lat >= 40) check("out_valid_timeout", 0, 1);
        q = quot;
        o = ovf;
        z = dbz;
        repeat (hold) @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    function automatic logic [9:0] model(input logic [7:0] n, input logic [7:0] d);
        logic       s;
        int         nm, dm, q, r;
        s  = n[7] ^ d[7];
        nm = int'(n[6:0]);
        dm = int'(d[6:0]);
        if (dm == 0) return {1'b0, 1'b1, s, 7'h7F};
        if (nm >= dm) return {1'b1, 1'b0, s, 7'h7F};
        q = (nm * 128) / dm;
        r = (nm * 128) % dm;
`ifdef FXDIV_ROUND_EN
        if (2 * r >= dm) q++;
        if (q == 128) return {1'b1, 1'b0, s, 7'h7F};
`endif
        return {1'b0, 1'b0, s, 7'(q)};
    endfunction

    vec_t vecs[12];

    initial begin
        logic [7:0] q;
        logic       o, z;
        logic [9:0] m;
        int         lat;
        int         hold;

        vecs[0]  = '{8'h20, 8'h40, 8'h40, 8'h40, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{8'hA0, 8'h40, 8'hC0, 8'hC0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{8'hA0, 8'hC0, 8'h40, 8'h40, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{8'h10, 8'h30, 8'h2A, 8'h2B, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{8'h10, 8'h80, 8'hFF, 8'hFF, 1'b0, 1'b1, 1'b1};
        vecs[5]  = '{8'h40, 8'h20, 8'h7F, 8'h7F, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{8'h00, 8'h80, 8'hFF, 8'hFF, 1'b0, 1'b1, 1'b1};
        vecs[7]  = '{8'h80, 8'h05, 8'h80, 8'h80, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{8'h7E, 8'h7F, 8'h7E, 8'h7F, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{8'h01, 8'h7F, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{8'h33, 8'hB3, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1};
        vecs[11] = '{8'h05, 8'h07, 8'h5B, 8'h5B, 1'b0, 1'b0, 1'b0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; num = '0; den = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_quot", int'(quot), 0);
        check("rst_ovf", int'(ovf), 0);
        check("rst_dbz", int'(dbz), 0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            do_op(vecs[i].n, vecs[i].d, 0, q, o, z, lat);
`ifdef FXDIV_ROUND_EN
            check($sformatf("vec%0d_quot", i), int'(q), int'(vecs[i].q_round));
`else
            check($sformatf("vec%0d_quot", i), int'(q), int'(vecs[i].q_trunc));
`endif
            check($sformatf("vec%0d_ovf", i), int'(o), int'(vecs[i].o));
            check($sformatf("vec%0d_dbz", i), int'(z), int'(vecs[i].z));
            check($sformatf("vec%0d_lat", i), lat, vecs[i].early ? 0 : LAT);
        end

        // Backpressure: result must hold and busy in_valid pulses be ignored.
        @(negedge clk);
        in_valid = 1'b1; num = 8'h20; den = 8'h40;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("bp_lat", lat, LAT);
        for (int c = 0; c < 5; c++) begin
            in_valid = c[0]; num = 8'h40; den = 8'h20;
            @(posedge clk);
            #1;
            check("bp_valid", int'(out_valid), 1);
            check("bp_quot", int'(quot), 8'h40);
            check("bp_flags", int'({ovf, dbz}), 0);
            check("bp_in_ready", int'(in_ready), 0);
        end
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid = 1'b0;
        check("bp_release_valid", int'(out_valid), 0);
        check("bp_release_in_ready", int'(in_ready), 1);
        repeat (3) @(posedge clk);
        #1;
        check("bp_no_spurious", int'({out_valid, in_ready}), 1);

        // Reset in the middle of a division.
        @(negedge clk);
        in_valid = 1'b1; num = 8'h10; den = 8'h30;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_out_valid", int'(out_valid), 0);
        check("abort_quot", int'(quot), 0);
        check("abort_in_ready", int'(in_ready), 1);
        repeat (10) @(posedge clk);
        #1;
        check("abort_no_result", int'(out_valid), 0);
        do_op(8'h05, 8'h07, 0, q, o, z, lat);
        check("abort_fresh_quot", int'(q), 8'h5B);
        check("abort_fresh_lat", lat, LAT);

        // Random pairs against the reference model with random result backpressure.
        for (int i = 0; i < 300; i++) begin
            logic [7:0] rn, rd;
            rn = 8'($urandom);
            rd = 8'($urandom);
            if (i % 3 == 0) rd[6:0] = 7'($urandom_range(127, 1)) | 7'h40;
            if (i % 3 == 0) rn[6:0] = 7'($urandom_range(63, 0));
            hold = int'($urandom_range(3, 0));
            m = model(rn, rd);
            do_op(rn, rd, hold, q, o, z, lat);
            check($sformatf("rand%0d_%02h_%02h", i, rn, rd), int'({o, z, q}), int'(m));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
